// File: rtl/digit_scan_pkg.sv
// rtl/digit_scan_pkg.sv - shared constants and state type for the digit scan controller
package digit_scan_pkg;

   localparam logic [3:0] BCD_BLANK  = 4'hF;
   localparam int         MAX_DIGITS = 8;
   localparam int         IDX_W      = $clog2(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } scan_state_e;

endpackage

// File: rtl/digit_scan_ctrl_scan_timer.sv
// rtl/digit_scan_ctrl_scan_timer.sv - loadable down-counter timing the BLANK and SHOW dwells
module scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_count;

   // Counts down to zero and parks there; a load of N-1 yields an N-cycle dwell.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - multiplexed BCD display scanner; DIGIT_SCAN_LZB_EN adds leading-zero blanking
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int SHOW_CYCLES  = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_addr,
   input  logic [3:0]            wr_data,
   output logic [3:0]            bcd_out,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic [IDX_W-1:0]      scan_idx,
   output logic                  frame_tick
);

   localparam int TMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] SHOW_LD  = TW'(SHOW_CYCLES - 1);
   localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);

   scan_state_e                 r_state;
   logic [NUM_DIGITS-1:0][3:0]  r_digits;
   logic [NUM_DIGITS-1:0][3:0]  w_digits_nxt;
   logic [IDX_W-1:0]            r_scan_idx;
   logic [3:0]                  r_bcd;
   logic [NUM_DIGITS-1:0]       r_sel;
   logic                        r_frame_tick;
   logic                        r_wr_ready;
   logic                        w_wr_fire;
   logic                        w_done;
   logic                        w_tmr_clear;
   logic                        w_tmr_load;
   logic [TW-1:0]               w_tmr_val;
   logic                        w_last;
   logic [3:0]                  w_show_bcd;
`ifdef DIGIT_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0]       w_lzb_mask;
   logic                        w_zero_run;
`endif

   assign w_wr_fire = wr_valid && r_wr_ready;
   assign w_last    = (r_scan_idx == IDX_W'(NUM_DIGITS - 1));

   // Post-write view of the register file, so a write landing on SHOW entry is displayed at once.
   always_comb begin
      w_digits_nxt = r_digits;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_wr_fire && (wr_addr == IDX_W'(i))) begin
            w_digits_nxt[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_digits <= {NUM_DIGITS{BCD_BLANK}};
      end else begin
         r_digits <= w_digits_nxt;
      end
   end

`ifdef DIGIT_SCAN_LZB_EN
   always_comb begin
      w_zero_run = 1'b1;
      w_lzb_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run    = w_zero_run && (w_digits_nxt[i] == 4'h0);
         w_lzb_mask[i] = (i != 0) && w_zero_run;
      end
   end
`endif

   always_comb begin
      w_show_bcd = BCD_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_scan_idx == IDX_W'(i)) begin
`ifdef DIGIT_SCAN_LZB_EN
            w_show_bcd = w_lzb_mask[i] ? BCD_BLANK : w_digits_nxt[i];
`else
            w_show_bcd = w_digits_nxt[i];
`endif
         end
      end
   end

   always_comb begin
      w_tmr_clear = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_val   = BLANK_LD;
      case (r_state)
         IDLE:    if (en) w_tmr_load = 1'b1; else w_tmr_clear = 1'b1;
         BLANK: begin
            if (!en) begin
               w_tmr_clear = 1'b1;
            end else if (w_done) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = SHOW_LD;
            end
         end
         SHOW: begin
            if (!en) w_tmr_clear = 1'b1;
            else if (w_done) w_tmr_load = 1'b1;
         end
         default: w_tmr_clear = 1'b1;
      endcase
   end

   scan_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_tmr_clear),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_scan_idx   <= '0;
         r_bcd        <= BCD_BLANK;
         r_sel        <= '0;
         r_frame_tick <= 1'b0;
         r_wr_ready   <= 1'b1;
      end else begin
         r_frame_tick <= 1'b0;
         case (r_state)
            IDLE: begin
               if (en) begin
                  r_state    <= BLANK;
                  r_scan_idx <= '0;
               end
            end
            BLANK: begin
               if (!en) begin
                  r_state    <= IDLE;
                  r_scan_idx <= '0;
               end else if (w_done) begin
                  r_state    <= SHOW;
                  r_bcd      <= w_show_bcd;
                  r_sel      <= NUM_DIGITS'(1) << r_scan_idx;
                  r_wr_ready <= 1'b0;
               end
            end
            SHOW: begin
               if (!en) begin
                  r_state    <= IDLE;
                  r_scan_idx <= '0;
                  r_bcd      <= BCD_BLANK;
                  r_sel      <= '0;
                  r_wr_ready <= 1'b1;
               end else if (w_done) begin
                  r_state      <= BLANK;
                  r_scan_idx   <= w_last ? '0 : r_scan_idx + IDX_W'(1);
                  r_frame_tick <= w_last;
                  r_bcd        <= BCD_BLANK;
                  r_sel        <= '0;
                  r_wr_ready   <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_scan_idx <= '0;
               r_bcd      <= BCD_BLANK;
               r_sel      <= '0;
               r_wr_ready <= 1'b1;
            end
         endcase
      end
   end

   assign wr_ready   = r_wr_ready;
   assign bcd_out    = r_bcd;
   assign digit_sel  = r_sel;
   assign scan_idx   = r_scan_idx;
   assign frame_tick = r_frame_tick;

endmodule
